// File: rtl/apb_param_regbank_pkg.sv
// Shared types and constants for the parametrised APB register bank.
package apb_regbank_pkg;

   // Transfer sequencing states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Address map offsets (byte addresses, word aligned)
   localparam int CTRL_OFS = 0;
   localparam int REG_BASE = 4;

   // Width of the wait-state down-counter
   localparam int WAIT_CNT_W = 4;

   // Decoded error causes for a latched request
   localparam logic [2:0] ERR_NONE     = 3'd0;
   localparam logic [2:0] ERR_MISALIGN = 3'd1;
   localparam logic [2:0] ERR_RANGE    = 3'd2;
   localparam logic [2:0] ERR_RO_WRITE = 3'd3;
   localparam logic [2:0] ERR_NO_STRB  = 3'd4;

   // STATUS sits directly after the last data register
   function automatic int status_ofs(input int num_regs);
      return REG_BASE * (num_regs + 1);
   endfunction

endpackage

// File: rtl/apb_param_regbank_wait_ctr.sv
// Loadable 4-bit down-counter that paces the ACCESS phase of a transfer.
module apb_wait_ctr
   import apb_regbank_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  dec,
   input  logic [WAIT_CNT_W-1:0] load_val,
   output logic                  zero
);

   logic [WAIT_CNT_W-1:0] cnt_d;
   logic [WAIT_CNT_W-1:0] cnt_q;

   // Load has priority; decrement stops at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_param_regbank.sv
// Parametrised APB4 slave register bank: CTRL, NUM_REGS data registers and a
// read-only STATUS word, with byte strobes, wait states and error responses.
module apb_param_regbank
   import apb_regbank_pkg::*;
#(
   parameter int                         ADDR_W      = 32,
   parameter int                         DATA_W      = 32,
   parameter int                         NUM_REGS    = 4,
   parameter int                         WAIT_STATES = 0,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS  = '0
) (
   input  logic                       pclk,
   input  logic                       presetn,
   input  logic [ADDR_W-1:0]          paddr,
   input  logic                       psel,
   input  logic                       penable,
   input  logic                       pwrite,
   input  logic [DATA_W-1:0]          pwdata,
   input  logic [DATA_W/8-1:0]        pstrb,
   output logic [DATA_W-1:0]          prdata,
   output logic                       pready,
   output logic                       pslverr,
   output logic [NUM_REGS-1:0]        cntrl_o,
   output logic [NUM_REGS*DATA_W-1:0] regs_o
);

   localparam int STRB_W     = DATA_W / 8;
   localparam int STATUS_OFS = status_ofs(NUM_REGS);

   // Byte-lane merge of new write data over the current register value
   function automatic logic [DATA_W-1:0] strb_merge(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
      logic [DATA_W-1:0] res;
      res = old_v;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) begin
            res[b*8 +: 8] = new_v[b*8 +: 8];
         end
      end
      return res;
   endfunction

   // Saturating 8-bit increment for the error counter
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   apb_state_e state_d, state_q;

   logic [ADDR_W-1:0] addr_d, addr_q;
   logic              wr_d, wr_q;
   logic [DATA_W-1:0] wdata_d, wdata_q;
   logic [STRB_W-1:0] strb_d, strb_q;

   logic [NUM_REGS-1:0] ctrl_d, ctrl_q;
   logic [7:0]          err_cnt_d, err_cnt_q;
   logic [7:0]          wr_cnt_d, wr_cnt_q;
   logic [DATA_W-1:0]   prdata_d, prdata_q;
   logic                pready_d, pready_q;
   logic                pslverr_d, pslverr_q;

   logic                capture;
   logic                ctr_load;
   logic                ctr_dec;
   logic                ctr_zero;
   logic                done;
   logic                wr_commit;
   logic [2:0]          err_code;
   logic                is_ctrl;
   logic                is_status;
   logic [NUM_REGS-1:0] reg_sel;
   logic [DATA_W-1:0]   rd_val;
   logic [DATA_W-1:0]   reg_rd [NUM_REGS];

   apb_wait_ctr u_wait_ctr (
      .clk      (pclk),
      .rst_n    (presetn),
      .load     (ctr_load),
      .dec      (ctr_dec),
      .load_val (WAIT_CNT_W'(WAIT_STATES)),
      .zero     (ctr_zero)
   );

   // Next-state logic. The request is latched on leaving IDLE; SETUP covers the
   // first penable cycle, so with no wait states the transfer completes at the
   // end of it and pready shows in the second penable cycle.
   always_comb begin
      state_d  = state_q;
      capture  = 1'b0;
      ctr_load = 1'b0;
      ctr_dec  = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               capture  = 1'b1;
               ctr_load = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP, ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (penable) begin
               if (ctr_zero) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else begin
                  ctr_dec = 1'b1;
                  state_d = ACCESS;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request holding registers: later bus changes within a transfer are ignored
   always_comb begin
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      if (capture) begin
         addr_d  = paddr;
         wr_d    = pwrite;
         wdata_d = pwdata;
         strb_d  = pstrb;
      end
   end

   // Request holding flops (data only, never read before a capture)
   always_ff @(posedge pclk) begin
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
   end

   // Address decode and error classification of the latched request
   always_comb begin
      is_ctrl   = (addr_q == ADDR_W'(CTRL_OFS));
      is_status = (addr_q == ADDR_W'(STATUS_OFS));
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_sel[i] = (addr_q == ADDR_W'(REG_BASE + 4 * i));
      end
      err_code = ERR_NONE;
      if (addr_q[1:0] != 2'b00) begin
         err_code = ERR_MISALIGN;
      end else if (addr_q > ADDR_W'(STATUS_OFS)) begin
         err_code = ERR_RANGE;
      end else if (wr_q && is_status) begin
         err_code = ERR_RO_WRITE;
      end else if (wr_q && (strb_q == '0)) begin
         err_code = ERR_NO_STRB;
      end
   end

   // Read mux; CTRL and STATUS are zero-extended to the bus width
   always_comb begin
      rd_val = '0;
      if (is_ctrl) begin
         rd_val = DATA_W'(ctrl_q);
      end else if (is_status) begin
         rd_val = DATA_W'({wr_cnt_q, err_cnt_q});
      end
      for (int i = 0; i < NUM_REGS; i++) begin
         if (reg_sel[i]) begin
            rd_val = reg_rd[i];
         end
      end
   end

   // Completion: response, counters and CTRL update on the final access edge
   always_comb begin
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      err_cnt_d = err_cnt_q;
      wr_cnt_d  = wr_cnt_q;
      ctrl_d    = ctrl_q;
      wr_commit = 1'b0;
      if (done) begin
         pready_d = 1'b1;
         if (err_code != ERR_NONE) begin
            pslverr_d = 1'b1;
            err_cnt_d = sat_inc8(err_cnt_q);
         end else if (wr_q) begin
            wr_commit = 1'b1;
            wr_cnt_d  = wr_cnt_q + 8'd1;
            if (is_ctrl && strb_q[0]) begin
               ctrl_d = NUM_REGS'(wdata_q);
            end
         end else begin
            prdata_d = rd_val;
         end
      end
   end

   // Response, counter and CTRL registers
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         err_cnt_q <= '0;
         wr_cnt_q  <= '0;
         ctrl_q    <= '0;
      end else begin
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
         err_cnt_q <= err_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         ctrl_q    <= ctrl_d;
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] reg_d;
      logic [DATA_W-1:0] reg_q;

      // Strobed write into this register when it is the committed target
      always_comb begin
         reg_d = reg_q;
         if (wr_commit && reg_sel[gi]) begin
            reg_d = strb_merge(reg_q, wdata_q, strb_q);
         end
      end

      // Data register with its own reset value
      always_ff @(posedge pclk or negedge presetn) begin
         if (!presetn) begin
            reg_q <= RESET_VALS[gi*DATA_W +: DATA_W];
         end else begin
            reg_q <= reg_d;
         end
      end

      assign reg_rd[gi]                  = reg_q;
      assign regs_o[gi*DATA_W +: DATA_W] = reg_q;
   end

   assign prdata  = prdata_q;
   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign cntrl_o = ctrl_q;

endmodule
